// File: rtl/fdc_code_averager_pkg.sv
// Shared definitions for the FDC code averager: default widths, the window FSM
// state type and the sum-width helper.
package fdc_pkg;

  localparam int CODE_W_DEF = 5;
  localparam int LOG2_N_DEF = 4;

  function automatic int sum_width(input int code_w, input int log2_n);
    return code_w + log2_n;
  endfunction

  localparam int SUM_W = sum_width(CODE_W_DEF, LOG2_N_DEF);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/fdc_code_averager_if.sv
// Result bus of the averager: window sum/min/max with a valid/ready handshake.
interface fdc_code_averager_if
  import fdc_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int SUM_W  = fdc_pkg::SUM_W
);

  logic [SUM_W-1:0]  sum_out;
  logic [CODE_W-1:0] min_out;
  logic [CODE_W-1:0] max_out;
  logic              res_valid;
  logic              res_ready;

  modport master (output sum_out, min_out, max_out, res_valid, input res_ready);
  modport slave  (input sum_out, min_out, max_out, res_valid, output res_ready);

endinterface

// File: rtl/fdc_code_averager_result_hold.sv
// Single-entry result holding register with valid/ready handshake and
// dropped-window status (sticky overrun, saturating drop counter).
module fdc_result_hold
  import fdc_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int SUM_W  = fdc_pkg::SUM_W,
  parameter int DROP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [SUM_W-1:0]    i_sum,
  input  logic [CODE_W-1:0]   i_min,
  input  logic [CODE_W-1:0]   i_max,
  input  logic                i_clr_status,
  fdc_code_averager_if.master res_if,
  output logic                o_overrun,
  output logic [DROP_W-1:0]   o_drop_cnt
);

  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [SUM_W-1:0]  r_sum;
  logic [CODE_W-1:0] r_min;
  logic [CODE_W-1:0] r_max;
  logic              r_valid;
  logic              r_overrun;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_take;
  logic              w_drop;
  logic [DROP_W-1:0] w_drop_inc;

  // A completed window is taken if the slot is empty or is being emptied this cycle.
  always_comb begin
    w_take     = i_load && (!r_valid || res_if.res_ready);
    w_drop     = i_load && r_valid && !res_if.res_ready;
    w_drop_inc = (r_drop_cnt == DROP_MAX) ? DROP_MAX : (r_drop_cnt + DROP_ONE);
  end

  // Holding register and status flags; a coinciding drop beats clr_status.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum      <= '0;
      r_min      <= '0;
      r_max      <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_take) begin
        r_sum   <= i_sum;
        r_min   <= i_min;
        r_max   <= i_max;
        r_valid <= 1'b1;
      end else if (r_valid && res_if.res_ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun  <= 1'b1;
        r_drop_cnt <= i_clr_status ? DROP_ONE : w_drop_inc;
      end else if (i_clr_status) begin
        r_overrun  <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  assign res_if.sum_out   = r_sum;
  assign res_if.min_out   = r_min;
  assign res_if.max_out   = r_max;
  assign res_if.res_valid = r_valid;
  assign o_overrun        = r_overrun;
  assign o_drop_cnt       = r_drop_cnt;

endmodule

// File: rtl/fdc_code_averager.sv
// FDC code averager: accumulates windows of 2^LOG2_N codes into sum/min/max and
// hands each finished window to the result holding register.
module fdc_code_averager
  import fdc_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int DROP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CODE_W-1:0]   code_in,
  input  logic                code_valid,
  fdc_code_averager_if.master res_if,
  output logic                overrun,
  output logic [DROP_W-1:0]   drop_cnt,
  input  logic                clr_status
);

  localparam int                ACC_W    = sum_width(CODE_W, LOG2_N);
  localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};

  state_e            r_state;
  logic [LOG2_N-1:0] r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [CODE_W-1:0] r_min;
  logic [CODE_W-1:0] r_max;

  state_e            w_state_nxt;
  logic [LOG2_N-1:0] w_cnt_nxt;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [CODE_W-1:0] w_min_nxt;
  logic [CODE_W-1:0] w_max_nxt;
  logic [ACC_W-1:0]  w_sum_fin;
  logic [CODE_W-1:0] w_min_fin;
  logic [CODE_W-1:0] w_max_fin;
  logic              w_done;

  // Window state, counter and running statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_min   <= {CODE_W{1'b1}};
      r_max   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_min   <= w_min_nxt;
      r_max   <= w_max_nxt;
    end
  end

  // Next-state logic; the completing sample's values feed the holding register
  // while the window itself restarts, so back-to-back strobes lose nothing.
  always_comb begin
    w_sum_fin   = r_acc + {{LOG2_N{1'b0}}, code_in};
    w_min_fin   = (code_in < r_min) ? code_in : r_min;
    w_max_fin   = (code_in > r_max) ? code_in : r_max;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_min_nxt   = r_min;
    w_max_nxt   = r_max;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_acc_nxt = '0;
        w_min_nxt = {CODE_W{1'b1}};
        w_max_nxt = '0;
        if (enable) begin
          w_state_nxt = ACCUM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (!enable || (code_valid && (r_cnt == CNT_LAST))) begin
          w_state_nxt = enable ? ACCUM : IDLE;
          w_done      = enable;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
          w_min_nxt   = {CODE_W{1'b1}};
          w_max_nxt   = '0;
        end else if (code_valid) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          w_acc_nxt = w_sum_fin;
          w_min_nxt = w_min_fin;
          w_max_nxt = w_max_fin;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_acc_nxt   = '0;
        w_min_nxt   = {CODE_W{1'b1}};
        w_max_nxt   = '0;
      end
    endcase
  end

  fdc_result_hold #(
    .CODE_W (CODE_W),
    .SUM_W  (ACC_W),
    .DROP_W (DROP_W)
  ) u_hold (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_done),
    .i_sum        (w_sum_fin),
    .i_min        (w_min_fin),
    .i_max        (w_max_fin),
    .i_clr_status (clr_status),
    .res_if       (res_if),
    .o_overrun    (overrun),
    .o_drop_cnt   (drop_cnt)
  );

endmodule

// File: doc/fdc_code_averager.md
Name: fdc_code_averager

Overview:
Downstream consumer of the FDC core's CODE_W-bit frequency code. Captures one code per code_valid strobe and accumulates windows of 2^LOG2_N samples. Per window it produces the sum (the mean as fixed-point with LOG2_N fraction bits), the minimum and the maximum. Results go to a single-entry holding register with a valid/ready handshake, plus overrun/drop status for the readout logic.

Parameters:
CODE_W, 5, width of FDC code input
LOG2_N, 4, log2 of samples per window (N = 16 default; legal 1..8)
DROP_W, 8, width of saturating dropped-window counter

Ports:
clk  input  1  system clock; sole clock of the block
reset  input  1  synchronous, active-high reset
enable  input  1  level; high = accumulate, low = abort window and idle
code_in  input  CODE_W  FDC code, already in clk domain
code_valid  input  1  one-cycle strobe; code_in valid this cycle
sum_out  output  CODE_W+LOG2_N  window sum (mean = sum_out / 2^LOG2_N)
min_out  output  CODE_W  minimum code in window
max_out  output  CODE_W  maximum code in window
res_valid  output  1  holding register full
res_ready  input  1  consumer accepts when res_valid && res_ready
overrun  output  1  sticky; a completed window was dropped
drop_cnt  output  DROP_W  saturating count of dropped windows
clr_status  input  1  one-cycle pulse; clears overrun and drop_cnt

Behaviour:
- Reset (synchronous, active-high; dominates all other inputs): state IDLE; sample counter 0; accumulator 0; running min all-ones; running max 0. sum_out, min_out, max_out, res_valid, overrun, drop_cnt all 0.
- FSM states: IDLE, ACCUM.
- IDLE -> ACCUM when enable=1. No sample is taken in the transition cycle.
- ACCUM -> IDLE when enable=0. The partial window is discarded (counter, accumulator, min and max return to their reset values). The holding register is untouched.
- ACCUM sample (code_valid=1):
  - acc += code_in, zero-extended to CODE_W+LOG2_N bits; this cannot overflow.
  - min = min(min, code_in); max = max(max, code_in).
  - counter increments.
- code_valid in IDLE is ignored.
- Window completion: the cycle in which the 2^LOG2_N-th sample is taken.
  - The final values include that sample.
  - Next cycle: counter, accumulator, min and max are re-initialised and FSM stays in ACCUM.
  - Back-to-back strobes on consecutive cycles must be supported with no lost sample.
- Handoff at completion:
  - If res_valid=0, or res_valid && res_ready in the same cycle, load sum/min/max into the outputs and set res_valid=1 on the next edge. Latency: 1 cycle after the final strobe.
  - Otherwise drop the window: the holding register keeps its old result, overrun is set, and drop_cnt increments, saturating at 2^DROP_W-1.
- res_valid clears on handshake when no simultaneous load occurs. Outputs are stable while res_valid && !res_ready.
- Status clearing:
  - clr_status clears overrun and drop_cnt.
  - If clr_status and a drop coincide, the drop wins: overrun=1, drop_cnt=1.
- enable=0 at the completion cycle: the completing sample is discarded with the window. Enable is checked first and no result is produced.
- The holding register and status flags are unaffected by enable.

Decomposition:
- Shared package fdc_pkg holds:
  - CODE_W default
  - the state enum (IDLE, ACCUM)
  - localparam helper SUM_W = CODE_W+LOG2_N
- One natural sub-module, fdc_result_hold: the single-entry holding register with valid/ready and drop detection.
- The accumulator, min/max and FSM stay in the top module.

Test Plan:
- Constant code 10, 16 strobes every 3 cycles, res_ready=1 -> sum_out=160, min_out=10, max_out=10, res_valid pulses 1 cycle, 1 cycle after 16th strobe.
- Ramp codes 0..15, back-to-back strobes -> sum_out=120, min_out=0, max_out=15; next window starts with no lost sample. Repeat with codes 31 x16 -> sum_out=496, no overflow.
- res_ready=0 across 3 windows of codes 1,2,3 -> output holds window 1 (sum 16), overrun=1, drop_cnt=2. Then clr_status -> both 0.
- Window 2 completes in the same cycle res_ready=1 accepts window 1 -> window 2 (sum 32) loaded next cycle, no drop, res_valid stays 1.
- enable dropped after 7 samples, then re-raised and 16 samples of code 5 -> no result from the partial window; sum_out=80.
- reset asserted mid-window with res_valid=1 -> next cycle all outputs 0 and state IDLE. A following full window of code 2 gives sum_out=32.
